fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin arbiter/sequencer that shares the single write port of the async FIFO write-side pointer block among NREQ requesters, all in the I_WR_CLK domain.
- Grants one requester at a time and locks the grant for a burst. The burst ends on LAST, on MAX_BURST beats, or on an idle timeout.
- Muxes the granted data and source ID onto the FIFO write port.
- Gates writes with the FIFO's registered full flag so no write is ever issued while full.

Parameters:
- NREQ, 4, number of requesters (2..16); IDW = max(1, clog2(NREQ)) is a derived localparam.
- DW, 8, write data width; must match the FIFO data width.
- MAX_BURST, 8, maximum beats per grant (>=1).
- IDLE_TMO, 4, consecutive cycles with granted valid low before the grant is released (>=1).

Ports:
- I_WR_CLK  in  1  write-domain clock
- I_WR_RST_N  in  1  asynchronous active-low reset
- I_REQ_VALID  in  NREQ  per-requester beat valid
- I_REQ_DATA  in  NREQ*DW  per-requester data; requester k occupies [k*DW +: DW]
- I_REQ_LAST  in  NREQ  per-requester last beat of a burst
- O_REQ_READY  out  NREQ  per-requester accept; one-hot or zero
- I_WR_FULL  in  1  registered full flag from the FIFO write side
- O_WR_EN  out  1  FIFO write enable
- O_WR_DATA  out  DW  FIFO write data
- O_WR_SRC  out  IDW  index of the granted requester (sideband)
- O_GNT  out  NREQ  one-hot current grant
- O_BUSY  out  1  state == GRANT

Behaviour:
- Clocking and reset: I_WR_RST_N is asynchronous, active-low; clock is I_WR_CLK.
- Reset values:
  - state = IDLE, r_gnt = 0, beat_cnt = 0, idle_cnt = 0.
  - Last-grant pointer = NREQ-1, so requester 0 wins first.
  - All outputs 0.
- States: IDLE, GRANT.
- IDLE:
  - O_REQ_READY = 0, O_WR_EN = 0.
  - If any I_REQ_VALID is high, the RR winner is registered into r_gnt and the block moves to GRANT.
  - Arbitration latency is 1 cycle.
- GRANT (g = granted index):
  - O_REQ_READY[g] = ~I_WR_FULL; all other ready bits are 0.
  - O_WR_EN = I_REQ_VALID[g] & ~I_WR_FULL. This path is combinational, so the data and the enable land in the same cycle.
  - O_WR_DATA = I_REQ_DATA[g]; O_WR_SRC = g. Both are combinational from r_gnt.
  - A beat is the cycle where O_WR_EN = 1; each beat increments beat_cnt.
  - Full stall: beat_cnt and idle_cnt hold, and there is no timeout while full.
  - idle_cnt increments when ~I_REQ_VALID[g] & ~I_WR_FULL, and clears on any beat.
- End of burst (evaluated in the current cycle), on any of:
  - a beat with I_REQ_LAST[g];
  - a beat with beat_cnt == MAX_BURST-1;
  - idle_cnt == IDLE_TMO-1 with I_REQ_VALID[g] low.
- On end of burst:
  - beat_cnt and idle_cnt clear; the last-grant pointer is set to g.
  - RR search starts at g+1 mod NREQ and includes g as lowest priority. Inputs are the current-cycle I_REQ_VALID, excluding g's bit if the ending beat consumed its LAST.
  - Winner found: r_gnt is loaded and the block stays in GRANT, giving back-to-back bursts with no bubble.
  - No winner: r_gnt = 0 and the block goes to IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... Each requester gets at most MAX_BURST consecutive beats.
- Full timing: I_WR_FULL rises the cycle after the beat that fills the FIFO. The arbiter relies on the FIFO's look-ahead full, so it never writes into a full FIFO.
- Reset mid-burst: all state clears immediately. The FIFO pointers share I_WR_RST_N, so no partial-burst recovery is required.
- MAX_BURST = 1 degenerates to a per-beat round robin.
- Invariants:
  - O_WR_EN implies |O_GNT and ~I_WR_FULL.
  - O_REQ_READY & ~O_GNT == 0.

Decomposition:
- Package fifo_wr_arb_pkg:
  - state enum (IDLE, GRANT);
  - clog2 function;
  - counter width derivation for MAX_BURST and IDLE_TMO.
- Submodule fifo_wr_rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector, last-grant index.
  - Outputs: one-hot winner, winner index, any.
  - Reused for both the IDLE and end-of-burst arbitration.

Test Plan:
- Single requester: req1 bursts 3 beats with LAST on the 3rd, FIFO empty → grant 1 cycle after valid; 3 consecutive O_WR_EN, O_WR_SRC = 1; returns to IDLE.
- All 4 continuously valid, no LAST, MAX_BURST = 8 → O_WR_SRC sequence 0×8, 1×8, 2×8, 3×8, 0×8; no bubble at the handovers.
- Full stall: I_WR_FULL forced high for 5 cycles mid-burst → O_WR_EN = 0 and ready = 0; beat_cnt holds; no timeout; burst resumes with the correct remaining beat count.
- Idle timeout: req2 granted, then drops valid for 4 cycles without LAST, while req3 is valid → on the 4th low cycle the grant moves to req3 the next cycle.
- FIFO depth 16: one requester streams 20 beats with the read side stopped → exactly 16 writes accepted, O_WR_EN never high while I_WR_FULL = 1.
- Reset asserted mid-burst → outputs 0 asynchronously; after release, requester 0 has first priority.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of a counter/index holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_rr_pick.sv
// Combinational rotate-priority picker: search starts after 'last', 'last' itself is lowest priority.
module fifo_wr_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_idx,
    output logic            any
);

    always_comb begin
        int idx;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx]) begin
                any         = 1'b1;
                win_idx     = IDW'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing the FIFO write port among NREQ requesters.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int DW        = 8,
    parameter  int MAX_BURST = 8,
    parameter  int IDLE_TMO  = 4,
    localparam int IDW       = cnt_w(NREQ)
) (
    input  logic                 I_WR_CLK,
    input  logic                 I_WR_RST_N,
    input  logic [NREQ-1:0]      I_REQ_VALID,
    input  logic [NREQ*DW-1:0]   I_REQ_DATA,
    input  logic [NREQ-1:0]      I_REQ_LAST,
    output logic [NREQ-1:0]      O_REQ_READY,
    input  logic                 I_WR_FULL,
    output logic                 O_WR_EN,
    output logic [DW-1:0]        O_WR_DATA,
    output logic [IDW-1:0]       O_WR_SRC,
    output logic [NREQ-1:0]      O_GNT,
    output logic                 O_BUSY
);

    localparam int BCW = cnt_w(MAX_BURST);
    localparam int ICW = cnt_w(IDLE_TMO);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TMO - 1);

    arb_state_t            state, state_nxt;
    logic [NREQ-1:0]       r_gnt, gnt_nxt;
    logic [IDW-1:0]        r_idx, idx_nxt;
    logic [IDW-1:0]        last_ptr, last_nxt;
    logic [BCW-1:0]        beat_cnt, beat_nxt;
    logic [ICW-1:0]        idle_cnt, idle_nxt;

    logic [NREQ-1:0][DW-1:0] req_data;
    logic                  busy, vg, lg, beat, eob;
    logic [NREQ-1:0]       pick_req, pick_oh;
    logic [IDW-1:0]        pick_last, pick_idx;
    logic                  pick_any;

    assign req_data = I_REQ_DATA;
    assign busy     = (state == ST_GRANT);
    assign vg       = I_REQ_VALID[r_idx];
    assign lg       = I_REQ_LAST[r_idx];
    assign beat     = busy & vg & ~I_WR_FULL;
    // A full FIFO freezes the burst entirely, including the idle timeout.
    assign eob      = busy & ((beat & (lg | (beat_cnt == BEAT_LAST))) |
                              (~vg & ~I_WR_FULL & (idle_cnt == IDLE_LAST)));

    // One picker serves both IDLE arbitration and the end-of-burst handover;
    // a requester whose LAST was just consumed is not eligible for re-grant.
    assign pick_req  = busy ? (I_REQ_VALID & ~(r_gnt & {NREQ{beat & lg}})) : I_REQ_VALID;
    assign pick_last = busy ? r_idx : last_ptr;

    fifo_wr_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (pick_req),
        .last    (pick_last),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign O_BUSY      = busy;
    assign O_GNT       = r_gnt;
    assign O_REQ_READY = r_gnt & {NREQ{~I_WR_FULL}};
    assign O_WR_EN     = beat;
    assign O_WR_SRC    = r_idx;
    assign O_WR_DATA   = busy ? req_data[r_idx] : '0;

    always_ff @(posedge I_WR_CLK or negedge I_WR_RST_N) begin
        if (!I_WR_RST_N) begin
            state    <= ST_IDLE;
            r_gnt    <= '0;
            r_idx    <= '0;
            last_ptr <= IDW'(NREQ - 1);
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            r_gnt    <= gnt_nxt;
            r_idx    <= idx_nxt;
            last_ptr <= last_nxt;
            beat_cnt <= beat_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = r_gnt;
        idx_nxt   = r_idx;
        last_nxt  = last_ptr;
        beat_nxt  = beat_cnt;
        idle_nxt  = idle_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = pick_oh;
                    idx_nxt   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (eob) begin
                    beat_nxt = '0;
                    idle_nxt = '0;
                    last_nxt = r_idx;
                    if (pick_any) begin
                        gnt_nxt = pick_oh;
                        idx_nxt = pick_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end else if (beat) begin
                    beat_nxt = beat_cnt + 1'b1;
                    idle_nxt = '0;
                end else if (!I_WR_FULL) begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized + directed bench for fifo_wr_arb against a behavioural round-robin model.
module tb_fifo_wr_arb;

    localparam int NREQ = 4, DW = 8, MAX_BURST = 8, IDLE_TMO = 4, IDW = 2, DEPTH = 16;

    logic                 I_WR_CLK = 1'b0;
    logic                 I_WR_RST_N;
    logic [NREQ-1:0]      I_REQ_VALID, I_REQ_LAST, O_REQ_READY, O_GNT;
    logic [NREQ*DW-1:0]   I_REQ_DATA;
    logic                 I_WR_FULL, O_WR_EN, O_BUSY;
    logic [DW-1:0]        O_WR_DATA;
    logic [IDW-1:0]       O_WR_SRC;

    always #5 I_WR_CLK = ~I_WR_CLK;

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .IDLE_TMO(IDLE_TMO)) dut (
        .I_WR_CLK    (I_WR_CLK),
        .I_WR_RST_N  (I_WR_RST_N),
        .I_REQ_VALID (I_REQ_VALID),
        .I_REQ_DATA  (I_REQ_DATA),
        .I_REQ_LAST  (I_REQ_LAST),
        .O_REQ_READY (O_REQ_READY),
        .I_WR_FULL   (I_WR_FULL),
        .O_WR_EN     (O_WR_EN),
        .O_WR_DATA   (O_WR_DATA),
        .O_WR_SRC    (O_WR_SRC),
        .O_GNT       (O_GNT),
        .O_BUSY      (O_BUSY)
    );

    int n_chk = 0, n_pass = 0;
    // Model: granted requester (-1 = none), beats/idle cycles of current burst, last grant.
    int m_g = -1, m_beats = 0, m_idle = 0, m_last = NREQ - 1;
    int fifo_cnt = 0;
    bit rd_on = 1'b1, force_full = 1'b0;
    logic [NREQ-1:0] s_gnt;
    int beat_log[$];

    function automatic int rr(input logic [NREQ-1:0] req, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            int k = (last + i) % NREQ;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic [NREQ-1:0] e_gnt, e_rdy, req;
        logic e_en, e_busy;
        logic [DW-1:0] e_data;
        int e_src;
        bit v, full, ends;
        @(negedge I_WR_CLK);
        s_gnt = O_GNT;
        if (O_WR_EN) beat_log.push_back(int'(O_WR_SRC));
        if (!I_WR_RST_N) begin
            m_g = -1; m_beats = 0; m_idle = 0; m_last = NREQ - 1;
        end else begin
            full = I_WR_FULL;
            v = 1'b0;
            e_gnt = '0; e_rdy = '0; e_en = 1'b0; e_busy = 1'b0; e_data = '0; e_src = 0;
            if (m_g >= 0) begin
                v = I_REQ_VALID[m_g];
                e_gnt[m_g] = 1'b1;
                e_rdy  = full ? '0 : e_gnt;
                e_en   = v && !full;
                e_busy = 1'b1;
                e_data = I_REQ_DATA[m_g*DW +: DW];
                e_src  = m_g;
            end
            chk("wr_en", O_WR_EN, e_en);
            chk("ready", O_REQ_READY, e_rdy);
            chk("gnt", O_GNT, e_gnt);
            chk("busy", O_BUSY, e_busy);
            chk("wr_src", O_WR_SRC, e_src);
            chk("wr_data", O_WR_DATA, e_data);
            chk("no_write_when_full", O_WR_EN & I_WR_FULL, 0);
            if (m_g < 0) begin
                m_g = rr(I_REQ_VALID, m_last);
            end else begin
                ends = (e_en && (I_REQ_LAST[m_g] || m_beats == MAX_BURST - 1)) ||
                       (!full && !v && m_idle == IDLE_TMO - 1);
                if (ends) begin
                    req = I_REQ_VALID;
                    if (e_en && I_REQ_LAST[m_g]) req[m_g] = 1'b0;
                    m_last = m_g;
                    m_g = rr(req, m_last);
                    m_beats = 0; m_idle = 0;
                end else if (e_en) begin
                    m_beats++; m_idle = 0;
                end else if (!full) begin
                    m_idle++;
                end
            end
            if (O_WR_EN) fifo_cnt++;
            if (rd_on && fifo_cnt > 0) fifo_cnt--;
        end
        @(posedge I_WR_CLK);
        #1;
        I_WR_FULL = force_full || (fifo_cnt >= DEPTH);
    endtask

    initial begin
        int bad, n0;
        I_WR_RST_N = 1'b0; I_REQ_VALID = '0; I_REQ_LAST = '0; I_REQ_DATA = '0; I_WR_FULL = 1'b0;
        repeat (2) tick();
        chk("reset_gnt", O_GNT, 0);
        chk("reset_busy", O_BUSY, 0);
        chk("reset_en", O_WR_EN, 0);
        I_WR_RST_N = 1'b1;

        // All requesters valid: 0x8,1x8,2x8,3x8,0x8 with no handover bubble.
        beat_log.delete();
        I_REQ_VALID = '1;
        repeat (41) begin I_REQ_DATA = $urandom(); tick(); end
        chk("rot_beats", beat_log.size(), 40);
        bad = 0;
        for (int i = 0; i < beat_log.size() && i < 40; i++) if (beat_log[i] != (i / 8) % 4) bad++;
        chk("rot_order", bad, 0);
        I_REQ_VALID = '0;
        repeat (6) tick();
        chk("drain_idle", O_BUSY, 0);

        // Single requester 1, three beats, LAST on the third.
        beat_log.delete();
        I_REQ_VALID = 4'b0010;
        tick();
        for (int b = 0; b < 3; b++) begin
            I_REQ_LAST = (b == 2) ? 4'b0010 : 4'b0000;
            I_REQ_DATA = $urandom();
            tick();
            if (b == 0) chk("single_first_gnt", s_gnt, 4'b0010);
        end
        I_REQ_VALID = '0; I_REQ_LAST = '0;
        tick();
        chk("single_beats", beat_log.size(), 3);
        bad = 0;
        foreach (beat_log[i]) if (beat_log[i] != 1) bad++;
        chk("single_src", bad, 0);
        chk("single_idle", O_BUSY, 0);

        // Full stall for 5 cycles after 3 beats of requester 0.
        beat_log.delete();
        I_REQ_VALID = 4'b0011;
        tick();
        repeat (3) tick();
        force_full = 1'b1; I_WR_FULL = 1'b1;
        repeat (5) tick();
        force_full = 1'b0; I_WR_FULL = 1'b0;
        repeat (8) tick();
        n0 = 0;
        while (n0 < beat_log.size() && beat_log[n0] == 0) n0++;
        chk("stall_burst_len", n0, 8);
        chk("stall_next_src", (beat_log.size() > 8) ? beat_log[8] : -1, 1);
        I_REQ_VALID = '0;
        repeat (6) tick();

        // Idle timeout: requester 2 goes quiet while 3 waits.
        I_REQ_VALID = 4'b0100;
        repeat (3) tick();
        I_REQ_VALID = 4'b1000;
        repeat (4) tick();
        chk("tmo_hold", s_gnt, 4'b0100);
        tick();
        chk("tmo_move", s_gnt, 4'b1000);
        I_REQ_VALID = '0;
        repeat (6) tick();

        // Depth-16 FIFO with reads stopped: exactly 16 writes.
        beat_log.delete();
        rd_on = 1'b0;
        I_REQ_VALID = 4'b0001;
        repeat (30) begin I_REQ_DATA = $urandom(); tick(); end
        chk("depth_writes", beat_log.size(), 16);
        chk("depth_full", I_WR_FULL, 1);
        I_REQ_VALID = '0; rd_on = 1'b1;
        repeat (25) tick();

        // Random traffic with random full pulses and read gaps.
        repeat (600) begin
            I_REQ_VALID = NREQ'($urandom());
            I_REQ_LAST  = NREQ'($urandom() & $urandom());
            I_REQ_DATA  = $urandom();
            force_full  = ($urandom_range(0, 9) == 0);
            rd_on       = ($urandom_range(0, 1) == 1);
            tick();
        end
        force_full = 1'b0; rd_on = 1'b1; I_REQ_VALID = '0;
        repeat (30) tick();

        // Reset mid-burst clears outputs without a clock edge.
        I_REQ_VALID = '1;
        repeat (5) tick();
        chk("pre_rst_busy", O_BUSY, 1);
        #2;
        I_WR_RST_N = 1'b0;
        #1;
        chk("async_rst_gnt", O_GNT, 0);
        chk("async_rst_en", O_WR_EN, 0);
        chk("async_rst_busy", O_BUSY, 0);
        chk("async_rst_rdy", O_REQ_READY, 0);
        tick();
        I_WR_RST_N = 1'b1;
        tick();
        tick();
        chk("post_rst_first", s_gnt, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
